// File: rtl/core_dec_pkg.sv
// Shared decode types for the issue path: opcode constants, decoded-field struct and field/immediate extraction.
package core_dec_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [6:0]  opcode;
  } dec_t;

  function automatic dec_t decode_fields(input logic [31:0] instr);
    dec_t d;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct7 = instr[31:25];
    case (instr[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR: d.imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:                     d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:                    d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                              instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:            d.imm = {instr[31:12], 12'h000};
      OPC_JAL:                       d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                              instr[30:21], 1'b0};
      default:                       d.imm = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/core_instr_decode.sv
// Combinational decode of one instruction into fields plus register-usage flags.
// Zero latency; no flow control. Illegal opcodes report no register usage so they never stall.
module core_instr_decode
  import core_dec_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd
);

  always_comb begin
    dec       = decode_fields(instr);
    illegal   = 1'b1;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        illegal   = 1'b0;
        writes_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        illegal   = 1'b0;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP: begin
        illegal   = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        illegal  = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
    // x0 is never tracked, so writes to it create no dependency
    if (instr[11:7] == 5'd0) writes_rd = 1'b0;
  end

endmodule

// File: rtl/core_issue_ctrl.sv
// Decode/issue controller: fetch FIFO, head decode, registered issue slot and 32-entry busy scoreboard.
// Accept -> id_valid one edge later, 1/clk; head waits on hazards or a held slot; if_ready = FIFO not full.
module core_issue_ctrl
  import core_dec_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [6:0]       id_opcode,
  output logic [4:0]       id_rd,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [2:0]       id_funct3,
  output logic [6:0]       id_funct7,
  output logic [31:0]      id_imm,
  output logic [XLEN-1:0]  id_pc,
  output logic             id_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]     fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            head_vld, push, pop, load, hazard;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  dec_t            head_dec, slot;
  logic            head_ill, head_rs1, head_rs2, head_wr;
  logic [31:0]     busy, busy_eff, wb_mask, set_mask;

  // if_ready depends only on the FIFO occupancy register, never on id_ready
  assign if_ready   = (count != (AW+1)'(DEPTH));
  assign head_vld   = (count != '0);
  assign push       = if_valid && if_ready && !flush;
  assign head_instr = fifo_instr[rd_ptr];
  assign head_pc    = fifo_pc[rd_ptr];

  core_instr_decode u_dec (
    .instr     (head_instr),
    .dec       (head_dec),
    .illegal   (head_ill),
    .uses_rs1  (head_rs1),
    .uses_rs2  (head_rs2),
    .writes_rd (head_wr)
  );

  // A writeback landing this cycle already unblocks the head (bypass)
  assign wb_mask  = wb_valid ? (32'h1 << wb_rd) : 32'h0;
  assign busy_eff = busy & ~wb_mask;
  assign hazard   = (head_rs1 && busy_eff[head_dec.rs1]) ||
                    (head_rs2 && busy_eff[head_dec.rs2]) ||
                    (head_wr  && busy_eff[head_dec.rd]);
  assign load     = head_vld && !hazard && (!id_valid || id_ready) && !flush;
  assign pop      = load;
  assign set_mask = (load && head_wr) ? (32'h1 << head_dec.rd) : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= if_instr;
      fifo_pc[wr_ptr]    <= if_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid   <= 1'b0;
      slot       <= '0;
      id_pc      <= '0;
      id_illegal <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid   <= 1'b1;
      slot       <= head_dec;
      id_pc      <= head_pc;
      id_illegal <= head_ill;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

  // Set is ORed after the clear so an issuing writer beats a same-cycle release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy_eff | set_mask) & ~32'h1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (head_vld && hazard && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign id_opcode = slot.opcode;
  assign id_rd     = slot.rd;
  assign id_rs1    = slot.rs1;
  assign id_rs2    = slot.rs2;
  assign id_funct3 = slot.funct3;
  assign id_funct7 = slot.funct7;
  assign id_imm    = slot.imm;

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: queue-based reference model checked every cycle plus literal spot checks.
module tb_core_issue_ctrl;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             if_valid = 1'b0, id_ready = 1'b0, wb_valid = 1'b0, flush = 1'b0;
  logic [31:0]      if_instr = '0;
  logic [XLEN-1:0]  if_pc = '0;
  logic [4:0]       wb_rd = '0;
  logic             if_ready, id_valid, id_illegal;
  logic [6:0]       id_opcode, id_funct7;
  logic [4:0]       id_rd, id_rs1, id_rs2;
  logic [2:0]       id_funct3;
  logic [31:0]      id_imm;
  logic [XLEN-1:0]  id_pc;
  logic [CNT_W-1:0] stall_cnt;

  core_issue_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_imm(id_imm), .id_pc(id_pc), .id_illegal(id_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction
  function automatic bit m_rs1(input logic [31:0] i);
    return m_legal(i[6:0]) && !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
  endfunction
  function automatic bit m_rs2(input logic [31:0] i);
    return i[6:0] inside {7'h23, 7'h63, 7'h33};
  endfunction
  function automatic bit m_wrd(input logic [31:0] i);
    return (i[6:0] inside {7'h13, 7'h33, 7'h03, 7'h67, 7'h6F, 7'h37, 7'h17}) && (i[11:7] != 5'd0);
  endfunction
  function automatic logic [31:0] m_imm(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 32'($signed(i[31:20]));
      7'h23:               return 32'($signed({i[31:25], i[11:7]}));
      7'h63:               return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'h37, 7'h17:        return {i[31:12], 12'h000};
      7'h6F:               return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:             return 32'h0;
    endcase
  endfunction

  logic [31:0]      q_instr[$];
  logic [XLEN-1:0]  q_pc[$];
  bit               m_vld;
  logic [31:0]      m_instr;
  logic [XLEN-1:0]  m_pc;
  bit [31:0]        m_busy;
  logic [CNT_W-1:0] m_stall;

  always @(posedge clk or posedge rst) begin : model
    bit full_b, ld, hz;
    bit [31:0] beff;
    logic [31:0] h;
    if (rst) begin
      q_instr.delete(); q_pc.delete();
      m_vld = 0; m_busy = '0; m_stall = '0;
    end else begin
      full_b = (q_instr.size() == DEPTH);
      beff = m_busy;
      if (wb_valid) beff[wb_rd] = 1'b0;
      ld = 0; hz = 0; h = '0;
      if (flush) begin
        q_instr.delete(); q_pc.delete();
        m_vld = 0;
        m_busy = beff;
      end else begin
        if (q_instr.size() > 0) begin
          h  = q_instr[0];
          hz = (m_rs1(h) && beff[h[19:15]]) || (m_rs2(h) && beff[h[24:20]]) ||
               (m_wrd(h) && beff[h[11:7]]);
          ld = !hz && (!m_vld || id_ready);
          if (hz && m_stall != '1) m_stall = m_stall + 1'b1;
        end
        if (ld) begin
          m_vld = 1; m_instr = h; m_pc = q_pc[0];
          void'(q_instr.pop_front()); void'(q_pc.pop_front());
          if (m_wrd(h)) beff[h[11:7]] = 1'b1;
        end else if (id_ready) begin
          m_vld = 0;
        end
        m_busy = beff;
        if (if_valid && !full_b) begin
          q_instr.push_back(if_instr); q_pc.push_back(if_pc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("if_ready", 64'(if_ready), 64'(q_instr.size() < DEPTH));
      chk("id_valid", 64'(id_valid), 64'(m_vld));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (m_vld) begin
        chk("id_opcode",  64'(id_opcode),  64'(m_instr[6:0]));
        chk("id_rd",      64'(id_rd),      64'(m_instr[11:7]));
        chk("id_funct3",  64'(id_funct3),  64'(m_instr[14:12]));
        chk("id_rs1",     64'(id_rs1),     64'(m_instr[19:15]));
        chk("id_rs2",     64'(id_rs2),     64'(m_instr[24:20]));
        chk("id_funct7",  64'(id_funct7),  64'(m_instr[31:25]));
        chk("id_imm",     64'(id_imm),     64'(m_imm(m_instr)));
        chk("id_pc",      64'(id_pc),      64'(m_pc));
        chk("id_illegal", 64'(id_illegal), 64'(!m_legal(m_instr[6:0])));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [XLEN-1:0] pc_n = 32'h1000;

  task automatic cyc(input bit v, input logic [31:0] ins, input bit rdy,
                     input bit wv, input logic [4:0] wr, input bit fl);
    if_valid = v; if_instr = ins; if_pc = pc_n; id_ready = rdy;
    wb_valid = wv; wb_rd = wr; flush = fl;
    if (v) pc_n = pc_n + 4;
    @(negedge clk);
  endtask
  task automatic push(input logic [31:0] ins, input bit rdy); cyc(1, ins, rdy, 0, 0, 0); endtask
  task automatic idle(input bit rdy);                         cyc(0, 0, rdy, 0, 0, 0); endtask
  task automatic wb(input logic [4:0] r, input bit rdy);      cyc(0, 0, rdy, 1, r, 0); endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // stream two addi back to back
    push(32'h00500093, 1); push(32'h00700113, 1);
    chk("t2 valid1", 64'(id_valid), 1); chk("t2 imm5", 64'(id_imm), 5);
    idle(1);
    chk("t2 valid2", 64'(id_valid), 1); chk("t2 imm7", 64'(id_imm), 7);
    chk("t2 no stall", 64'(stall_cnt), 0);
    wb(1, 1);
    chk("t2 drop", 64'(id_valid), 0);
    wb(2, 1);

    // RAW on x1, released by same-cycle writeback
    push(32'h00500093, 1); push(32'h001081B3, 1);
    idle(1); idle(1); idle(1);
    chk("t3 held", 64'(id_valid), 0); chk("t3 stall3", 64'(stall_cnt), 3);
    wb(1, 1);
    chk("t3 bypass load", 64'(id_valid), 1); chk("t3 rd", 64'(id_rd), 3);
    chk("t3 stall kept", 64'(stall_cnt), 3);

    // reset mid-stream while the slot is held and the FIFO has entries
    push(32'h00500093, 0); push(32'h00700113, 0);
    if_valid = 0; id_ready = 0; wb_valid = 0; flush = 0;
    #2 rst = 1'b1;
    #1;
    chk("t1 id_valid", 64'(id_valid), 0); chk("t1 if_ready", 64'(if_ready), 1);
    chk("t1 stall", 64'(stall_cnt), 0);   chk("t1 imm", 64'(id_imm), 0);
    chk("t1 pc", 64'(id_pc), 0);
    @(negedge clk);
    rst = 1'b0;
    push(32'h00318233, 1); idle(1);
    chk("t1 busy cleared", 64'(id_valid), 1); chk("t1 no stall", 64'(stall_cnt), 0);
    idle(1); wb(4, 1);

    // lw x5 loads the slot while x5 writes back: x5 stays busy
    push(32'h00002283, 1); wb(5, 1);
    push(32'h00528333, 1); idle(1);
    chk("t4 busy5 held", 64'(id_valid), 0); chk("t4 stall1", 64'(stall_cnt), 1);
    idle(1);
    chk("t4 stall2", 64'(stall_cnt), 2);
    wb(5, 1);
    chk("t4 release", 64'(id_valid), 1); chk("t4 rd6", 64'(id_rd), 6);
    idle(1); wb(6, 1);

    // backpressure with DEPTH+2 pushes, then flush with x9 still busy
    push(32'h00100493, 1); idle(1); idle(1);
    push(32'h00100013, 0); push(32'h00200013, 0); push(32'h00300013, 0);
    chk("t5 full", 64'(if_ready), 0);
    push(32'h00400013, 0);
    chk("t5 still full", 64'(if_ready), 0); chk("t5 slot stable", 64'(id_imm), 1);
    chk("t5 slot valid", 64'(id_valid), 1);
    cyc(1, 32'h00500013, 0, 0, 0, 1);
    chk("t5 flush valid", 64'(id_valid), 0); chk("t5 flush ready", 64'(if_ready), 1);
    push(32'h00048533, 1); idle(1);
    chk("t5 busy9 kept", 64'(id_valid), 0); chk("t5 stall3", 64'(stall_cnt), 3);
    wb(9, 1);
    chk("t5 release", 64'(id_valid), 1);
    idle(1); wb(10, 1);

    // x0 writes, illegal opcode, branch/store/lui/jal immediates
    push(32'h00100013, 1); push(32'h00100013, 1);
    chk("t6 x0 first", 64'(id_valid), 1);
    idle(1);
    chk("t6 x0 second", 64'(id_valid), 1); chk("t6 x0 no stall", 64'(stall_cnt), 3);
    idle(1);
    push(32'h000000FF, 1); idle(1);
    chk("t6 illegal", 64'(id_illegal), 1); chk("t6 ill opcode", 64'(id_opcode), 64'h7F);
    push(32'h001081B3, 1); idle(1);
    chk("t6 ill no busy", 64'(id_valid), 1); chk("t6 legal add", 64'(id_illegal), 0);
    push(32'hFE000EE3, 1); idle(1);
    chk("t6 beq imm", 64'(id_imm), 64'hFFFF_FFFC);
    push(32'h00302223, 1); idle(1);
    chk("t6 sw waits x3", 64'(stall_cnt), 4);
    wb(3, 1);
    chk("t6 sw imm", 64'(id_imm), 4);
    push(32'h123455B7, 1); push(32'h008000EF, 1); idle(1);
    chk("t6 jal imm", 64'(id_imm), 8);
    idle(1); wb(11, 1); wb(1, 1); idle(1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
